// File: rtl/fmul_issue.sv
// fmul_issue: issue/retire wrapper around a 2-stage, non-stallable fmul core.
//
// Operand pairs arrive through a 2-entry input queue. Each pair is issued to
// fmul when the queue is non-empty and a result slot is guaranteed. A valid/tag
// shift pipe follows the op through fmul, and the result is captured into a
// RES_DEPTH-entry result FIFO. That FIFO drains through a valid/ready handshake.
// Slots are guaranteed by the credit rule:
//   issue only while (ops in flight + results held) < RES_DEPTH
//
// Ports:
//   clk, rstn                 clock (rising edge), async active-low reset
//   in_valid/in_ready         operand handshake; in_s, in_t, in_tag payload
//   mul_s, mul_t              operands to fmul (0 when not issuing)
//   mul_d, mul_ovf, mul_udf   fmul outputs, valid while vpipe[LATENCY-1]
//   res_valid/res_ready       result handshake; res_d, res_tag, res_ovf, res_udf
//   busy                      any op queued, in flight or held
//
// Optional build macro FMUL_ISSUE_STICKY_FLAGS_EN adds:
//   flag_clr                  clears the sticky flags at the next edge
//   sticky_ovf, sticky_udf    set when a flagged result is popped downstream
//                             (a set on the same edge as flag_clr wins)

module fmul_issue #(
  parameter int TAG_W     = 4,
  parameter int LATENCY   = 2,
  parameter int RES_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_s,
  input  logic [31:0]      in_t,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      mul_s,
  output logic [31:0]      mul_t,
  input  logic [31:0]      mul_d,
  input  logic             mul_ovf,
  input  logic             mul_udf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_d,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_ovf,
  output logic             res_udf,
  output logic             busy
`ifdef FMUL_ISSUE_STICKY_FLAGS_EN
  ,
  input  logic             flag_clr,
  output logic             sticky_ovf,
  output logic             sticky_udf
`endif
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + $clog2(LATENCY + 1);

  // ---------------------------------------------------------------- input queue
  logic [31:0]      q_s   [2];
  logic [31:0]      q_t   [2];
  logic [TAG_W-1:0] q_tag [2];
  logic             q_wr;
  logic             q_rd;
  logic [1:0]       q_cnt;
  logic             q_nonempty;
  logic             q_push;

  // ---------------------------------------------------------------- shift pipe
  logic [LATENCY-1:0]            vpipe;
  logic [LATENCY-1:0][TAG_W-1:0] tpipe;
  logic [SUM_W-1:0]              inflight;
  logic                          issue;

  // ---------------------------------------------------------------- result FIFO
  logic [31:0]      r_d   [RES_DEPTH];
  logic [TAG_W-1:0] r_tag [RES_DEPTH];
  logic             r_ovf [RES_DEPTH];
  logic             r_udf [RES_DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             res_push;
  logic             res_pop;
  logic             res_full;

  assign q_nonempty = (q_cnt != 2'd0);
  assign in_ready   = (q_cnt != 2'd2);
  assign q_push     = in_valid && in_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + SUM_W'(vpipe[i]);
    end
  end

  // Credit check uses the current result count. A pop on the same edge only
  // frees a slot for the next cycle, so the check errs on the safe side.
  assign issue = q_nonempty && ((inflight + SUM_W'(r_cnt)) < SUM_W'(RES_DEPTH));

  assign mul_s = issue ? q_s[q_rd] : 32'd0;
  assign mul_t = issue ? q_t[q_rd] : 32'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_wr  <= 1'b0;
      q_rd  <= 1'b0;
      q_cnt <= 2'd0;
    end else begin
      if (q_push) q_wr <= ~q_wr;
      if (issue)  q_rd <= ~q_rd;
      q_cnt <= q_cnt + 2'(q_push) - 2'(issue);
    end
  end

  // Queue storage needs no reset; mul_s/mul_t are gated by issue.
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_s[q_wr]   <= in_s;
      q_t[q_wr]   <= in_t;
      q_tag[q_wr] <= in_tag;
    end
  end

  // The shift pipe is cleared on reset so stale fmul outputs are never captured.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vpipe <= '0;
      tpipe <= '0;
    end else begin
      vpipe[0] <= issue;
      tpipe[0] <= q_tag[q_rd];
      for (int i = 1; i < LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        tpipe[i] <= tpipe[i-1];
      end
    end
  end

  assign res_push  = vpipe[LATENCY-1];
  assign res_valid = (r_cnt != '0);
  assign res_pop   = res_valid && res_ready;
  assign res_full  = (r_cnt == CNT_W'(RES_DEPTH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (res_push) r_wr <= r_wr + PTR_W'(1);
      if (res_pop)  r_rd <= r_rd + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(res_push) - CNT_W'(res_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (res_push) begin
      r_d[r_wr]   <= mul_d;
      r_tag[r_wr] <= tpipe[LATENCY-1];
      r_ovf[r_wr] <= mul_ovf;
      r_udf[r_wr] <= mul_udf;
    end
  end

  assign res_d   = res_valid ? r_d[r_rd]   : 32'd0;
  assign res_tag = res_valid ? r_tag[r_rd] : '0;
  assign res_ovf = res_valid && r_ovf[r_rd];
  assign res_udf = res_valid && r_udf[r_rd];

  assign busy = q_nonempty || (|vpipe) || res_valid;

  // The credit rule makes this unreachable; firing means the issue gate is broken.
  a_res_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
                                      !(res_push && res_full));

`ifdef FMUL_ISSUE_STICKY_FLAGS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky_ovf <= 1'b0;
      sticky_udf <= 1'b0;
    end else begin
      if (res_pop && res_ovf) sticky_ovf <= 1'b1;
      else if (flag_clr)      sticky_ovf <= 1'b0;
      if (res_pop && res_udf) sticky_udf <= 1'b1;
      else if (flag_clr)      sticky_udf <= 1'b0;
    end
  end
`endif

endmodule
